// File: rtl/add_accumulator.sv
// add_accumulator: streams a programmed count of operands through a SIZE-bit adder, reporting sum and sticky flags.
// Optional clamping on signed overflow when ADD_ACC_SAT_EN is defined.
module add_accumulator #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t           state_q;
    logic [SIZE-1:0]  acc_q, acc_d, op, s;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, ovf_q, c, ovf;
    assign op = in_sub ? ~in_data : in_data;
    assign {c, s} = {1'b0, acc_q} + {1'b0, op} + {{SIZE{1'b0}}, in_sub};
    assign ovf = (acc_q[SIZE-1] == op[SIZE-1]) & (s[SIZE-1] != acc_q[SIZE-1]);
`ifdef ADD_ACC_SAT_EN
    // overflow direction follows the sign of the accumulator before the beat
    assign acc_d = ovf ? {acc_q[SIZE-1], {(SIZE-1){~acc_q[SIZE-1]}}} : s;
`else
    assign acc_d = s;
`endif
    assign in_ready     = state_q == ACC;
    assign out_valid    = state_q == DONE;
    assign busy         = state_q != IDLE;
    assign out_sum      = acc_q;
    assign out_carry    = carry_q;
    assign out_overflow = ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    acc_q   <= '0;
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    cnt_q   <= len;
                    state_q <= (len != '0) ? ACC : DONE;
                end
                ACC: if (in_valid) begin
                    acc_q   <= acc_d;
                    carry_q <= carry_q | c;
                    ovf_q   <= ovf_q | ovf;
                    cnt_q   <= cnt_q - 1'b1;
                    state_q <= (cnt_q == CNT_W'(1)) ? DONE : ACC;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_accumulator.sv
// tb_add_accumulator: randomized scoreboard bench for add_accumulator against an arithmetic run model.
module tb_add_accumulator;
    localparam int SIZE = 32, CNT_W = 8;
    localparam longint MAXP = 64'sh7FFFFFFF, MINN = -64'sh80000000;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, in_sub = 0, out_ready = 0;
    logic [CNT_W-1:0] len = '0;
    logic [SIZE-1:0] in_data = '0, out_sum;
    logic in_ready, out_valid, out_carry, out_overflow, busy;
    typedef struct packed {logic [31:0] sum; logic c; logic o;} res_t;
    res_t sbq[$];
    int checks = 0, errors = 0;
    logic [31:0] bd[16];
    logic bs[16];

    add_accumulator #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry(out_carry), .out_overflow(out_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    // Whole-run reference: signed/unsigned integer arithmetic on 64-bit values
    function automatic res_t model(input int n);
        longint a, r, ux, sa, sx;
        logic signed [31:0] t;
        logic o;
        res_t e;
        a = 0;
        e = '0;
        for (int i = 0; i < n; i++) begin
            t = signed'(a[31:0]);
            sa = t;
            t = signed'(bd[i]);
            sx = t;
            ux = {32'h0, bd[i]};
            if (bs[i]) begin
                e.c |= (a >= ux);
                r = sa - sx;
            end else begin
                e.c |= ((a + ux) > 64'hFFFFFFFF);
                r = sa + sx;
            end
            o = (r > MAXP) || (r < MINN);
            e.o |= o;
            a = r & 64'hFFFFFFFF;
`ifdef ADD_ACC_SAT_EN
            if (o) a = (r > 0) ? 64'h7FFFFFFF : 64'h80000000;
`endif
        end
        e.sum = a[31:0];
        return e;
    endfunction

    always @(negedge clk) begin : mon
        res_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", out_sum);
            end else begin
                e = sbq.pop_front();
                chk("sum", out_sum, e.sum);
                chkb("carry", out_carry, e.c);
                chkb("overflow", out_overflow, e.o);
            end
        end
    end

    task automatic do_run(input int n, input int gap, input int rdly, input bit poke);
        logic [31:0] held;
        sbq.push_back(model(n));
        start = 1;
        len = CNT_W'(n);
        @(posedge clk); #1 start = 0;
        chkb("busy_start", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1;
            in_data = bd[i];
            in_sub = bs[i];
            chkb("in_ready", in_ready, 1'b1);
            chkb("early_valid", out_valid, 1'b0);
            @(posedge clk); #1 in_valid = 0;
            in_data = $urandom;
            in_sub = 1'($urandom);
            if (i < n - 1) begin
                held = out_sum;
                for (int g = 0; g < gap; g++) begin
                    if (poke && g == 0) begin
                        start = 1;
                        len = 8'd3;
                    end
                    @(posedge clk); #1 start = 0;
                    chk("stall_sum", out_sum, held);
                    chkb("stall_ready", in_ready, 1'b1);
                    chkb("stall_valid", out_valid, 1'b0);
                end
            end
        end
        chkb("latency_valid", out_valid, 1'b1);
        held = out_sum;
        for (int k = 0; k < rdly; k++) begin
            @(posedge clk); #1;
            chkb("bp_valid", out_valid, 1'b1);
            chk("bp_sum", out_sum, held);
        end
        out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
        chkb("idle_busy", busy, 1'b0);
        chkb("idle_valid", out_valid, 1'b0);
        chk("retain_sum", out_sum, held);
    endtask

    task automatic set2(input logic [31:0] a, input logic sa, input logic [31:0] b, input logic sb);
        bd[0] = a; bs[0] = sa; bd[1] = b; bs[1] = sb;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] edge_v[6];
        int n;
        edge_v[0] = 32'h7FFFFFFF; edge_v[1] = 32'h80000000; edge_v[2] = 32'hFFFFFFFF;
        edge_v[3] = 32'h0; edge_v[4] = 32'h1; edge_v[5] = 32'hFFFFFFE1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", out_sum, 0);
        chkb("rst_carry", out_carry, 1'b0);
        chkb("rst_ovf", out_overflow, 1'b0);
        chkb("rst_valid", out_valid, 1'b0);
        chkb("rst_ready", in_ready, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        set2(32'hFFFFFFFF, 0, 32'h1, 0);        do_run(2, 0, 0, 0);
        set2(32'h7FFFFFFF, 0, 32'h1, 0);        do_run(2, 0, 0, 0);
        set2(32'hFFFFFFE1, 0, 32'hFFFFFFE1, 0); do_run(2, 0, 0, 0);
        set2(32'd5, 0, 32'd7, 1);               do_run(2, 0, 0, 0);
        set2(32'h80000000, 0, 32'h1, 1);        do_run(2, 2, 3, 1);
        do_run(0, 0, 1, 0);
        // abort a run with an asynchronous reset between clock edges
        set2(32'hFFFFFFFF, 0, 32'h2, 0);
        start = 1; len = 8'd4;
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_data = bd[i]; in_sub = 0;
            @(posedge clk); #1 in_valid = 0;
        end
        chk("pre_rst_sum", out_sum, 32'h1);
        #2 rst = 1;
        #1;
        chk("arst_sum", out_sum, 0);
        chkb("arst_carry", out_carry, 1'b0);
        chkb("arst_ovf", out_overflow, 1'b0);
        chkb("arst_busy", busy, 1'b0);
        chkb("arst_ready", in_ready, 1'b0);
        chkb("arst_valid", out_valid, 1'b0);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        bd[0] = 32'h12345678; bs[0] = 0;
        do_run(1, 0, 0, 0);
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                bd[i] = ($urandom_range(0, 1) == 0) ? $urandom : edge_v[$urandom_range(0, 5)];
                bs[i] = 1'($urandom);
            end
            do_run(n, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end
        repeat (2) @(posedge clk);
        chk("queue_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
